idu_queue: RTL and testbench



---
 rtl/idu_queue.sv | 215 +++++++++++++++++++++
 tb/tb_idu_queue.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/idu_queue.sv
// Decode stage: DEPTH-entry instruction queue between IFU and EXU.
// The head entry is decoded combinationally into register IDs, immediate, class and exceptions.
module idu_queue #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 2,
  parameter int EN_M  = 1,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [31:0]     i_ins,
  input  logic [XLEN-1:0] i_pc,
  input  logic            flush,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_pc,
  output logic [31:0]     o_ins,
  output logic [4:0]      o_rs1id,
  output logic [4:0]      o_rs2id,
  output logic [4:0]      o_rdid,
  output logic            o_rdwen,
  output logic [XLEN-1:0] o_imm,
  output logic [3:0]      o_opcls,
  output logic [2:0]      o_func3,
  output logic            o_except_en,
  output logic [XLEN-1:0] o_except_code,
  output logic            o_mret,
  output logic [CW-1:0]   o_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OPIMM  = 7'h13;
  localparam logic [6:0] OPC_OPIMMW = 7'h1B;
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_OPW    = 7'h3B;
  localparam logic [6:0] OPC_SYSTEM = 7'h73;

  localparam logic [31:0] INS_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INS_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INS_MRET   = 32'h3020_0073;

  logic [XLEN-1:0] pc_mem  [DEPTH];
  logic [31:0]     ins_mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            enq;
  logic            deq;

  assign o_ready = (count != CW'(DEPTH)) && !reset;
  assign o_valid = (count != '0);
  assign o_count = count;
  assign enq     = i_valid && o_ready;
  assign deq     = o_valid && i_ready;

  always_ff @(posedge clock) begin
    if (enq && !flush) begin
      pc_mem[wr_ptr]  <= i_pc;
      ins_mem[wr_ptr] <= i_ins;
    end
  end

  // DEPTH is a power of two, so pointer overflow is the wrap to 0.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + AW'(1);
      if (deq) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(enq) - CW'(deq);
    end
  end

  logic [XLEN-1:0] head_pc;
  logic [31:0]     head_ins;
  logic [6:0]      opc;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic [4:0]      f_rd;
  logic [4:0]      f_rs1;
  logic [4:0]      f_rs2;
  logic [11:0]     sys_imm;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic            is64;
  logic            f7_ok;

  assign head_pc  = pc_mem[rd_ptr];
  assign head_ins = ins_mem[rd_ptr];
  assign opc      = head_ins[6:0];
  assign f3       = head_ins[14:12];
  assign f7       = head_ins[31:25];
  assign f_rd     = head_ins[11:7];
  assign f_rs1    = head_ins[19:15];
  assign f_rs2    = head_ins[24:20];
  assign sys_imm  = head_ins[31:20];
  assign is64     = (XLEN == 64);

  assign imm_i = XLEN'($signed(head_ins[31:20]));
  assign imm_s = XLEN'($signed({head_ins[31:25], head_ins[11:7]}));
  assign imm_b = XLEN'($signed({head_ins[31], head_ins[7], head_ins[30:25], head_ins[11:8], 1'b0}));
  assign imm_u = XLEN'($signed({head_ins[31:12], 12'b0}));
  assign imm_j = XLEN'($signed({head_ins[31], head_ins[19:12], head_ins[20], head_ins[30:21], 1'b0}));

  // SUB/SRA use funct7 0x20; the M extension uses 0x01.
  assign f7_ok = (f7 == 7'h00) ||
                 ((f7 == 7'h20) && ((f3 == 3'd0) || (f3 == 3'd5))) ||
                 ((f7 == 7'h01) && (EN_M != 0));

  logic [3:0]      dec_cls;
  logic [4:0]      dec_rs1, dec_rs2, dec_rd;
  logic [XLEN-1:0] dec_imm;
  logic            dec_wen;
  logic            dec_ill;

  always_comb begin
    dec_cls = 4'd0;
    dec_rs1 = '0;
    dec_rs2 = '0;
    dec_rd  = '0;
    dec_imm = '0;
    dec_wen = 1'b0;
    dec_ill = 1'b0;
    case (opc)
      OPC_LUI:    begin dec_cls = 4'd7; dec_rd = f_rd; dec_imm = imm_u; dec_wen = 1'b1; end
      OPC_AUIPC:  begin dec_cls = 4'd8; dec_rd = f_rd; dec_imm = imm_u; dec_wen = 1'b1; end
      OPC_JAL:    begin dec_cls = 4'd5; dec_rd = f_rd; dec_imm = imm_j; dec_wen = 1'b1; end
      OPC_JALR:   begin dec_cls = 4'd6; dec_rd = f_rd; dec_rs1 = f_rs1; dec_imm = imm_i; dec_wen = 1'b1; end
      OPC_BRANCH: begin dec_cls = 4'd4; dec_rs1 = f_rs1; dec_rs2 = f_rs2; dec_imm = imm_b; end
      OPC_LOAD:   begin dec_cls = 4'd2; dec_rd = f_rd; dec_rs1 = f_rs1; dec_imm = imm_i; dec_wen = 1'b1; end
      OPC_STORE:  begin dec_cls = 4'd3; dec_rs1 = f_rs1; dec_rs2 = f_rs2; dec_imm = imm_s; end
      OPC_OPIMM: begin
        dec_cls = 4'd0; dec_rd = f_rd; dec_rs1 = f_rs1; dec_imm = imm_i; dec_wen = 1'b1;
        dec_ill = !is64 && ((f3 == 3'd1) || (f3 == 3'd5)) && head_ins[25];
      end
      OPC_OPIMMW: begin
        dec_cls = 4'd1; dec_rd = f_rd; dec_rs1 = f_rs1; dec_imm = imm_i; dec_wen = 1'b1;
        dec_ill = !is64;
      end
      OPC_OP: begin
        dec_cls = 4'd0; dec_rd = f_rd; dec_rs1 = f_rs1; dec_rs2 = f_rs2; dec_wen = 1'b1;
        dec_ill = !f7_ok;
      end
      OPC_OPW: begin
        dec_cls = 4'd1; dec_rd = f_rd; dec_rs1 = f_rs1; dec_rs2 = f_rs2; dec_wen = 1'b1;
        dec_ill = !f7_ok || !is64;
      end
      OPC_SYSTEM: begin
        if ((f3 == 3'd0) || (f3 == 3'd4)) begin
          dec_cls = 4'd10;
          dec_ill = !((sys_imm == 12'h000) || (sys_imm == 12'h001) || (sys_imm == 12'h302));
        end else begin
          dec_cls = 4'd9; dec_rd = f_rd; dec_rs1 = f_rs1; dec_imm = imm_i; dec_wen = 1'b1;
        end
      end
      default: dec_ill = 1'b1;
    endcase
  end

  always_comb begin
    o_pc          = '0;
    o_ins         = '0;
    o_rs1id       = '0;
    o_rs2id       = '0;
    o_rdid        = '0;
    o_rdwen       = 1'b0;
    o_imm         = '0;
    o_opcls       = 4'd0;
    o_func3       = '0;
    o_except_en   = 1'b0;
    o_except_code = '0;
    o_mret        = 1'b0;
    if (o_valid) begin
      o_pc    = head_pc;
      o_ins   = head_ins;
      o_func3 = f3;
      if (dec_ill) begin
        o_opcls       = 4'd15;
        o_except_en   = 1'b1;
        o_except_code = XLEN'(2);
      end else begin
        o_opcls = dec_cls;
        o_rs1id = dec_rs1;
        o_rs2id = dec_rs2;
        o_rdid  = dec_rd;
        o_imm   = dec_imm;
        o_rdwen = dec_wen && (dec_rd != 5'd0);
        o_mret  = (head_ins == INS_MRET);
        if (head_ins == INS_ECALL) begin
          o_except_en   = 1'b1;
          o_except_code = XLEN'(11);
        end else if (head_ins == INS_EBREAK) begin
          o_except_en   = 1'b1;
          o_except_code = XLEN'(3);
        end
      end
    end
  end

endmodule

// File: tb/tb_idu_queue.sv
// Bench for idu_queue: two instances (RV64 with M, RV32 without M) checked every cycle
// against a queue-plus-decode reference model, plus hand-computed literal expectations.
module tb_idu_queue;

  localparam int DEPTH = 2;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] ins;
  } ent_t;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] ins;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        wen;
    logic [63:0] imm;
    logic [3:0]  cls;
    logic [2:0]  f3;
    logic        exc;
    logic [63:0] code;
    logic        mret;
  } dec_t;

  int checks = 0;
  int failures = 0;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic        a_valid = 0, a_flush = 0, a_iready = 0;
  logic [31:0] a_ins = 0;
  logic [63:0] a_pc = 0;
  logic        a_oready, a_ovalid, a_wen, a_exc, a_mret;
  logic [63:0] a_opc, a_imm, a_code;
  logic [31:0] a_oins;
  logic [4:0]  a_rs1, a_rs2, a_rd;
  logic [3:0]  a_cls;
  logic [2:0]  a_f3;
  logic [1:0]  a_count;

  logic        b_valid = 0, b_flush = 0, b_iready = 0;
  logic [31:0] b_ins = 0;
  logic [31:0] b_pc = 0;
  logic        b_oready, b_ovalid, b_wen, b_exc, b_mret;
  logic [31:0] b_opc, b_imm, b_code;
  logic [31:0] b_oins;
  logic [4:0]  b_rs1, b_rs2, b_rd;
  logic [3:0]  b_cls;
  logic [2:0]  b_f3;
  logic [1:0]  b_count;

  idu_queue #(.XLEN(64), .DEPTH(DEPTH), .EN_M(1)) dut_a (
    .clock(clock), .reset(reset), .i_valid(a_valid), .o_ready(a_oready), .i_ins(a_ins),
    .i_pc(a_pc), .flush(a_flush), .o_valid(a_ovalid), .i_ready(a_iready), .o_pc(a_opc),
    .o_ins(a_oins), .o_rs1id(a_rs1), .o_rs2id(a_rs2), .o_rdid(a_rd), .o_rdwen(a_wen),
    .o_imm(a_imm), .o_opcls(a_cls), .o_func3(a_f3), .o_except_en(a_exc),
    .o_except_code(a_code), .o_mret(a_mret), .o_count(a_count)
  );

  idu_queue #(.XLEN(32), .DEPTH(DEPTH), .EN_M(0)) dut_b (
    .clock(clock), .reset(reset), .i_valid(b_valid), .o_ready(b_oready), .i_ins(b_ins),
    .i_pc(b_pc), .flush(b_flush), .o_valid(b_ovalid), .i_ready(b_iready), .o_pc(b_opc),
    .o_ins(b_oins), .o_rs1id(b_rs1), .o_rs2id(b_rs2), .o_rdid(b_rd), .o_rdwen(b_wen),
    .o_imm(b_imm), .o_opcls(b_cls), .o_func3(b_f3), .o_except_en(b_exc),
    .o_except_code(b_code), .o_mret(b_mret), .o_count(b_count)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference decode: pick the format and class from the opcode, then build fields from the format.
  function automatic dec_t mdl(input bit vld, input logic [63:0] pc, input logic [31:0] w,
                               input int xlen, input bit en_m);
    dec_t d;
    byte fmt;
    int cls;
    bit ill;
    longint imm;
    logic [2:0] f3;
    logic [6:0] f7;
    d = '0;
    if (!vld) return d;
    f3 = w[14:12];
    f7 = w[31:25];
    fmt = "N";
    cls = 0;
    ill = 0;
    imm = 0;
    case (w[6:0])
      7'h33, 7'h3B: begin
        fmt = "R";
        cls = (w[6:0] == 7'h3B) ? 1 : 0;
        ill = !(f7 == 0 || (f7 == 7'h20 && (f3 == 0 || f3 == 5)) || (f7 == 7'h01 && en_m));
        if (w[6:0] == 7'h3B && xlen == 32) ill = 1;
      end
      7'h13: begin fmt = "I"; cls = 0; ill = (xlen == 32) && (f3 == 1 || f3 == 5) && w[25]; end
      7'h1B: begin fmt = "I"; cls = 1; ill = (xlen == 32); end
      7'h03: begin fmt = "I"; cls = 2; end
      7'h23: begin fmt = "S"; cls = 3; end
      7'h63: begin fmt = "B"; cls = 4; end
      7'h6F: begin fmt = "J"; cls = 5; end
      7'h67: begin fmt = "I"; cls = 6; end
      7'h37: begin fmt = "U"; cls = 7; end
      7'h17: begin fmt = "U"; cls = 8; end
      7'h73: begin
        if (f3 == 0 || f3 == 4) begin
          cls = 10;
          ill = !(w[31:20] inside {12'h000, 12'h001, 12'h302});
        end else begin
          fmt = "I";
          cls = 9;
        end
      end
      default: ill = 1;
    endcase
    d.pc  = (xlen == 32) ? (pc & 64'hFFFF_FFFF) : pc;
    d.ins = w;
    d.f3  = f3;
    if (ill) begin
      d.cls = 4'd15;
      d.exc = 1'b1;
      d.code = 64'd2;
      return d;
    end
    d.cls = 4'(cls);
    case (fmt)
      "R": begin d.rd = w[11:7]; d.rs1 = w[19:15]; d.rs2 = w[24:20]; end
      "I": begin
        d.rd = w[11:7]; d.rs1 = w[19:15];
        imm = longint'(w[31:20]); if (w[31]) imm -= 4096;
      end
      "S": begin
        d.rs1 = w[19:15]; d.rs2 = w[24:20];
        imm = longint'({w[31:25], w[11:7]}); if (w[31]) imm -= 4096;
      end
      "B": begin
        d.rs1 = w[19:15]; d.rs2 = w[24:20];
        imm = longint'({w[31], w[7], w[30:25], w[11:8]}) * 2; if (w[31]) imm -= 8192;
      end
      "U": begin
        d.rd = w[11:7];
        imm = longint'(w[31:12]) * 4096; if (w[31]) imm -= 64'h1_0000_0000;
      end
      "J": begin
        d.rd = w[11:7];
        imm = longint'({w[31], w[19:12], w[20], w[30:21]}) * 2; if (w[31]) imm -= 2097152;
      end
      default: imm = 0;
    endcase
    d.imm  = (xlen == 32) ? (imm & 64'hFFFF_FFFF) : imm;
    d.wen  = (fmt inside {"R", "I", "U", "J"}) && (d.rd != 0);
    d.mret = (w == 32'h3020_0073);
    if (w == 32'h0000_0073) begin d.exc = 1; d.code = 11; end
    else if (w == 32'h0010_0073) begin d.exc = 1; d.code = 3; end
    return d;
  endfunction

  task automatic chk_dec(input string p, input dec_t a, input dec_t e);
    chk({p, "_pc"},   a.pc,   e.pc);
    chk({p, "_ins"},  64'(a.ins),  64'(e.ins));
    chk({p, "_rs1"},  64'(a.rs1),  64'(e.rs1));
    chk({p, "_rs2"},  64'(a.rs2),  64'(e.rs2));
    chk({p, "_rd"},   64'(a.rd),   64'(e.rd));
    chk({p, "_wen"},  64'(a.wen),  64'(e.wen));
    chk({p, "_imm"},  a.imm,  e.imm);
    chk({p, "_cls"},  64'(a.cls),  64'(e.cls));
    chk({p, "_f3"},   64'(a.f3),   64'(e.f3));
    chk({p, "_exc"},  64'(a.exc),  64'(e.exc));
    chk({p, "_code"}, a.code, e.code);
    chk({p, "_mret"}, 64'(a.mret), 64'(e.mret));
  endtask

  ent_t qa[$];
  ent_t qb[$];

  // Model queues follow the handshake rules; flush empties, reset empties at once.
  always @(posedge clock or posedge reset) begin
    bit ra, da, rb, db;
    if (reset) begin
      qa.delete();
      qb.delete();
    end else begin
      ra = qa.size() < DEPTH;
      da = qa.size() != 0 && a_iready;
      rb = qb.size() < DEPTH;
      db = qb.size() != 0 && b_iready;
      if (da) $display("txn A pc=%h ins=%h", qa[0].pc, qa[0].ins);
      if (db) $display("txn B pc=%h ins=%h", qb[0].pc, qb[0].ins);
      if (a_flush) qa.delete();
      else begin
        if (da) void'(qa.pop_front());
        if (a_valid && ra) qa.push_back('{pc: a_pc, ins: a_ins});
      end
      if (b_flush) qb.delete();
      else begin
        if (db) void'(qb.pop_front());
        if (b_valid && rb) qb.push_back('{pc: {32'b0, b_pc}, ins: b_ins});
      end
    end
  end

  always @(negedge clock) begin
    dec_t ea, eb, da, db;
    logic [63:0] hpc;
    logic [31:0] hins;
    hpc = 0; hins = 0;
    if (qa.size() != 0) begin hpc = qa[0].pc; hins = qa[0].ins; end
    ea = mdl(qa.size() != 0, hpc, hins, 64, 1'b1);
    hpc = 0; hins = 0;
    if (qb.size() != 0) begin hpc = qb[0].pc; hins = qb[0].ins; end
    eb = mdl(qb.size() != 0, hpc, hins, 32, 1'b0);
    da = '{pc: a_opc, ins: a_oins, rs1: a_rs1, rs2: a_rs2, rd: a_rd, wen: a_wen, imm: a_imm,
           cls: a_cls, f3: a_f3, exc: a_exc, code: a_code, mret: a_mret};
    db = '{pc: {32'b0, b_opc}, ins: b_oins, rs1: b_rs1, rs2: b_rs2, rd: b_rd, wen: b_wen,
           imm: {32'b0, b_imm}, cls: b_cls, f3: b_f3, exc: b_exc, code: {32'b0, b_code},
           mret: b_mret};
    chk("A_valid", 64'(a_ovalid), 64'(qa.size() != 0));
    chk("A_ready", 64'(a_oready), 64'(!reset && qa.size() < DEPTH));
    chk("A_count", 64'(a_count), 64'(qa.size()));
    chk_dec("A", da, ea);
    chk("B_valid", 64'(b_ovalid), 64'(qb.size() != 0));
    chk("B_ready", 64'(b_oready), 64'(!reset && qb.size() < DEPTH));
    chk("B_count", 64'(b_count), 64'(qb.size()));
    chk_dec("B", db, eb);
  end

  task automatic cyc();
    @(negedge clock);
    #1;
  endtask

  task automatic show_a(input logic [31:0] w, input logic [63:0] pc);
    a_valid = 1; a_ins = w; a_pc = pc; a_iready = 0;
    cyc();
    a_valid = 0;
  endtask

  task automatic show_b(input logic [31:0] w, input logic [31:0] pc);
    b_valid = 1; b_ins = w; b_pc = pc; b_iready = 0;
    cyc();
    b_valid = 0;
  endtask

  task automatic drain();
    a_valid = 0; b_valid = 0; a_iready = 1; b_iready = 1;
    cyc(); cyc();
    a_iready = 0; b_iready = 0;
  endtask

  logic [31:0] tbl [20] = '{
    32'h0050_0093, 32'h4020_8133, 32'h0020_D1B3, 32'h4020_F233, 32'h0081_2283,
    32'hFE11_2E23, 32'hFE00_06E3, 32'h0080_006F, 32'h0003_00E7, 32'h1234_5537,
    32'h0000_1517, 32'h3000_2573, 32'h3000_1073, 32'h0000_000F, 32'h0200_1093,
    32'h0020_0073, 32'h1050_0073, 32'h0000_403B, 32'h0220_8033, 32'h8000_00B7
  };

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc(); cyc();
    chk("rst_valid", 64'(a_ovalid), 64'd0);
    chk("rst_ready", 64'(a_oready), 64'd0);
    chk("rst_count", 64'(a_count), 64'd0);
    reset = 0;
    cyc();
    chk("ready_after_rst", 64'(a_oready), 64'd1);

    // Single instruction: addi x1,x0,5
    show_a(32'h0050_0093, 64'h8000_0000);
    chk("single_valid", 64'(a_ovalid), 64'd1);
    chk("single_rd", 64'(a_rd), 64'd1);
    chk("single_imm", a_imm, 64'd5);
    chk("single_wen", 64'(a_wen), 64'd1);
    chk("single_cls", 64'(a_cls), 64'd0);
    chk("single_count", 64'(a_count), 64'd1);
    chk("single_pc", a_opc, 64'h8000_0000);
    drain();

    // Back-pressure: three offers, two taken.
    a_valid = 1; a_ins = 32'h0010_0113; a_pc = 64'h100; cyc();
    a_ins = 32'h0020_0193; a_pc = 64'h104; cyc();
    chk("full_count", 64'(a_count), 64'd2);
    chk("full_ready", 64'(a_oready), 64'd0);
    a_ins = 32'h0030_0213; a_pc = 64'h108; cyc();
    chk("third_not_taken", 64'(a_count), 64'd2);
    chk("order_head0", a_opc, 64'h100);
    a_valid = 0; a_iready = 1; cyc();
    chk("order_head1", a_opc, 64'h104);
    chk("drain_count", 64'(a_count), 64'd1);
    cyc();
    chk("drained_valid", 64'(a_ovalid), 64'd0);

    // Full with i_ready high: no enqueue in that cycle.
    a_iready = 0; a_valid = 1; a_ins = 32'h0040_0293; a_pc = 64'h200; cyc();
    a_pc = 64'h204; cyc();
    a_iready = 1; a_pc = 64'h208;
    #1;
    chk("full_iready_ready", 64'(a_oready), 64'd0);
    cyc();
    chk("full_iready_count", 64'(a_count), 64'd1);
    cyc();
    chk("simul_count", 64'(a_count), 64'd1);
    chk("simul_head", a_opc, 64'h208);
    a_flush = 1; a_iready = 0; a_valid = 1; cyc();
    a_flush = 0; a_valid = 0;
    chk("flush_valid", 64'(a_ovalid), 64'd0);
    chk("flush_count", 64'(a_count), 64'd0);

    // Exceptions
    show_a(32'h0000_0073, 64'h300);
    chk("ecall_exc", 64'(a_exc), 64'd1);
    chk("ecall_code", a_code, 64'd11);
    drain();
    show_a(32'h0010_0073, 64'h304);
    chk("ebreak_code", a_code, 64'd3);
    drain();
    show_a(32'h3020_0073, 64'h308);
    chk("mret_flag", 64'(a_mret), 64'd1);
    chk("mret_exc", 64'(a_exc), 64'd0);
    drain();
    show_a(32'hFFFF_FFFF, 64'h30C);
    chk("ill_cls", 64'(a_cls), 64'd15);
    chk("ill_code", a_code, 64'd2);
    chk("ill_wen", 64'(a_wen), 64'd0);
    drain();

    // Parameter variants
    show_a(32'h0000_009B, 64'h400);
    show_b(32'h0000_009B, 32'h400);
    chk("addiw_rv64", 64'(a_cls), 64'd1);
    chk("addiw_rv32", 64'(b_cls), 64'd15);
    drain();
    show_a(32'h0220_8033, 64'h404);
    show_b(32'h0220_8033, 32'h404);
    chk("mul_enm1", 64'(a_cls), 64'd0);
    chk("mul_enm0", 64'(b_cls), 64'd15);
    drain();

    // Negative immediates
    show_a(32'hFFF0_0093, 64'h500);
    show_b(32'hFFF0_0093, 32'h500);
    chk("negimm_rv64", a_imm, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("negimm_rv32", {32'b0, b_imm}, 64'h0000_0000_FFFF_FFFF);
    drain();
    show_a(32'hFFFF_F0B7, 64'h504);
    chk("lui_imm", a_imm, 64'hFFFF_FFFF_FFFF_F000);
    chk("lui_rs1", 64'(a_rs1), 64'd0);
    drain();

    // Asynchronous reset with two entries queued
    a_valid = 1; a_ins = 32'h0050_0093; a_pc = 64'h600; cyc();
    a_pc = 64'h604; cyc();
    a_valid = 0;
    chk("prerst_count", 64'(a_count), 64'd2);
    #2 reset = 1;
    #1;
    chk("async_rst_valid", 64'(a_ovalid), 64'd0);
    chk("async_rst_count", 64'(a_count), 64'd0);
    cyc();
    reset = 0;
    cyc();

    // Mixed stream through both instances with intermittent back-pressure
    for (int i = 0; i < 20; i++) begin
      a_valid = 1; b_valid = 1;
      a_ins = tbl[i]; b_ins = tbl[i];
      a_pc = 64'hFFFF_0000_0000_1000 + 64'(i * 4);
      b_pc = 32'h8000_1000 + 32'(i * 4);
      a_iready = (i % 5) != 4;
      b_iready = (i % 3) != 2;
      cyc();
    end
    drain();
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
